// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead subtractor.
//   - cla_state_e : FSM state encoding (StIdle / StRun / StDone)
//   - SLICE       : bits handled by the lookahead slice per clock
//   - sat_pos/neg : clamp values for a given width (largest positive / most negative)
//   - SAT_POS/NEG : clamp values for the default 16-bit width
package cla_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } cla_state_e;

  localparam int unsigned SLICE     = 4;
  localparam int unsigned WIDTH_DEF = 16;

  // Widths up to 64 bits are supported by the clamp helpers.
  function automatic logic [63:0] sat_pos(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

  localparam logic [WIDTH_DEF-1:0] SAT_POS = WIDTH_DEF'(sat_pos(WIDTH_DEF));
  localparam logic [WIDTH_DEF-1:0] SAT_NEG = WIDTH_DEF'(sat_neg(WIDTH_DEF));

endpackage

// File: rtl/cla_sub_slice4.sv
// Combinational 4-bit carry-lookahead slice.
// Subtraction is done by the caller feeding the inverted subtrahend nibble.
// Ports:
//   x    in  4  first operand nibble
//   y    in  4  second operand nibble (already inverted for subtraction)
//   cin  in  1  carry-in
//   sum  out 4  x + y + cin (low 4 bits)
//   cout out 1  carry-out
//   gp   out 1  group propagate
//   gg   out 1  group generate
module cla_sub_slice4
  import cla_pkg::*;
(
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             gp,
  output logic             gg
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;

  always_comb begin
    p = x ^ y;
    g = x & y;
    // Flattened lookahead equations: every carry derives directly from cin.
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    gp   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    c[4] = gg | (gp & cin);
    sum  = p ^ c[SLICE-1:0];
    cout = c[SLICE];
  end

endmodule

// File: rtl/cla_sub_seq.sv
// Multi-cycle WIDTH-bit subtractor: d = (a - b - bin) mod 2^WIDTH.
// One 4-bit lookahead slice is reused, one nibble per clock, LSB first.
// Optional macro CLA_SUB_SAT_EN: on signed overflow the result is clamped to the
// largest positive / most negative value instead of wrapping.
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      synchronous active-high reset
//   start in  1      request, sampled in IDLE or DONE
//   a     in  WIDTH  minuend
//   b     in  WIDTH  subtrahend
//   bin   in  1      borrow-in
//   busy  out 1      operation in progress
//   done  out 1      one-cycle pulse, result valid
//   d     out WIDTH  difference, held until next accepted start
//   bout  out 1      borrow-out
//   ovf   out 1      signed overflow
//   zero  out 1      d == 0
module cla_sub_seq
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NIB  = WIDTH / SLICE;
  localparam int unsigned CNTW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NIB - 1);

  cla_state_e state_q, state_d;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic             carry_q;
  logic             bout_q, ovf_q, zero_q;

  logic             accept;
  logic             last;
  logic [SLICE-1:0] a_nib, b_nib, sum_nib;
  logic             slice_cout, slice_gp, slice_gg;
  logic [WIDTH-1:0] d_next, d_res;
  logic             ovf_next;

  // Group P/G are not needed here because the slice already resolves carry-out.
  logic unused_pg;
  assign unused_pg = slice_gp ^ slice_gg;

  always_comb begin
    a_nib = a_q[int'(cnt_q) * SLICE +: SLICE];
    b_nib = ~b_q[int'(cnt_q) * SLICE +: SLICE];
  end

  cla_sub_slice4 u_slice (
    .x    (a_nib),
    .y    (b_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (slice_cout),
    .gp   (slice_gp),
    .gg   (slice_gg)
  );

  always_comb begin
    d_next = d_q;
    d_next[int'(cnt_q) * SLICE +: SLICE] = sum_nib;
    // Operands of differing sign overflow when the result sign leaves the minuend's.
    ovf_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_next[WIDTH-1] != a_q[WIDTH-1]);
`ifdef CLA_SUB_SAT_EN
    if (ovf_next) begin
      d_res = a_q[WIDTH-1] ? WIDTH'(sat_neg(WIDTH)) : WIDTH'(sat_pos(WIDTH));
    end else begin
      d_res = d_next;
    end
`else
    d_res = d_next;
`endif
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    last    = (cnt_q == CNT_LAST);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (last) state_d = StDone;
      end
      StDone: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      carry_q <= 1'b1;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= ~bin;
      cnt_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state_q == StRun) begin
      carry_q <= slice_cout;
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        d_q    <= d_res;
        bout_q <= ~slice_cout;
        ovf_q  <= ovf_next;
        zero_q <= (d_res == '0);
      end else begin
        d_q <= d_next;
      end
    end
  end

  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
